// File: rtl/trade_report_packer_pkg.sv
// Shared constants, header layout and FSM encoding for the trade report packer.
package trade_report_packer_pkg;

  localparam logic [15:0] TRADE_MAGIC = 16'h7B01;

  localparam int unsigned HDR_MAGIC_MSB = 31;
  localparam int unsigned HDR_MAGIC_LSB = 16;
  localparam int unsigned HDR_SEQ_MSB   = 15;
  localparam int unsigned HDR_SEQ_LSB   = 8;
  localparam int unsigned HDR_CNT_MSB   = 7;
  localparam int unsigned HDR_CNT_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_TS   = 2'd2,
    ST_PAY  = 2'd3
  } state_e;

  // Frame header: {magic, sequence number, payload word count}
  function automatic logic [31:0] make_hdr(input logic [7:0] seq, input logic [7:0] cnt);
    logic [31:0] h;
    h = '0;
    h[HDR_MAGIC_MSB:HDR_MAGIC_LSB] = TRADE_MAGIC;
    h[HDR_SEQ_MSB:HDR_SEQ_LSB]     = seq;
    h[HDR_CNT_MSB:HDR_CNT_LSB]     = cnt;
    return h;
  endfunction

endpackage

// File: rtl/trade_report_packer_fifo.sv
// Synchronous first-word-fall-through FIFO; full/empty derive from the registered level.
module trade_report_packer_fifo #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout,
  output logic          o_empty,
  output logic          o_full,
  output logic [AW:0]   o_level
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_dout  = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset; only pointer-covered entries are ever read out
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/trade_report_packer.sv
// Buffers trade words and emits framed AXI-Stream batches (header, optional timestamp, payload).
// Optional feature: define TRADE_PACKER_TIMESTAMP_EN to send a cycle-count timestamp after the header.
module trade_report_packer
  import trade_report_packer_pkg::*;
#(
  parameter int unsigned FIFO_AW       = 6,
  parameter int unsigned MAX_BATCH     = 16,
  parameter int unsigned FLUSH_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_trade_valid,
  input  logic [31:0]        i_trade_info,
  output logic [31:0]        o_m_tdata,
  output logic               o_m_tvalid,
  input  logic               i_m_tready,
  output logic               o_m_tlast,
  output logic [FIFO_AW:0]   o_fifo_level,
  output logic [15:0]        o_overflow_count,
  output logic               o_busy
);

  localparam int unsigned LVL_W = FIFO_AW + 1;
  localparam int unsigned TMR_W = $clog2(FLUSH_TIMEOUT + 1);

  state_e             r_state;
  logic [7:0]         r_seq;
  logic [7:0]         r_n;
  logic [7:0]         r_cnt;
  logic [TMR_W-1:0]   r_timer;
  logic [15:0]        r_ovf;
  logic [31:0]        w_fifo_dout;
  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic [LVL_W-1:0]   w_level;
  logic               w_start;
  logic               w_pay_hs;
  logic               w_last;
  logic [7:0]         w_n;
  logic [31:0]        w_tdata;
`ifdef TRADE_PACKER_TIMESTAMP_EN
  logic [31:0]        r_ts;
  logic [31:0]        r_ts_lat;
`endif

  trade_report_packer_fifo #(.AW(FIFO_AW), .DW(32)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (i_trade_valid),
    .i_pop   (w_pay_hs),
    .i_din   (i_trade_info),
    .o_dout  (w_fifo_dout),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_level (w_level)
  );

  assign w_start  = (r_state == ST_IDLE) &&
                    ((w_level >= LVL_W'(MAX_BATCH)) ||
                     (!w_fifo_empty && (r_timer == TMR_W'(FLUSH_TIMEOUT))));
  assign w_n      = (w_level >= LVL_W'(MAX_BATCH)) ? 8'(MAX_BATCH) : 8'(w_level);
  assign w_pay_hs = (r_state == ST_PAY) && i_m_tready;
  assign w_last   = (r_cnt == (r_n - 8'd1));

  // Frame sequencing; n is frozen at frame start so later arrivals roll into the next frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_seq   <= '0;
      r_n     <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_n     <= w_n;
            r_cnt   <= '0;
            r_state <= ST_HDR;
          end
        end
        ST_HDR: begin
`ifdef TRADE_PACKER_TIMESTAMP_EN
          if (i_m_tready) r_state <= ST_TS;
`else
          if (i_m_tready) r_state <= ST_PAY;
`endif
        end
        ST_TS: begin
          if (i_m_tready) r_state <= ST_PAY;
        end
        ST_PAY: begin
          if (i_m_tready) begin
            if (w_last) begin
              r_seq   <= r_seq + 8'd1;
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Idle flush timer: only runs while waiting in IDLE with data buffered
  always_ff @(posedge clk) begin
    if (!rst_n || w_fifo_empty || w_start) begin
      r_timer <= '0;
    end else if ((r_state == ST_IDLE) && (r_timer != TMR_W'(FLUSH_TIMEOUT))) begin
      r_timer <= r_timer + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= '0;
    end else if (i_trade_valid && w_fifo_full && (r_ovf != 16'hFFFF)) begin
      r_ovf <= r_ovf + 16'd1;
    end
  end

`ifdef TRADE_PACKER_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ts     <= '0;
      r_ts_lat <= '0;
    end else begin
      r_ts <= r_ts + 32'd1;
      if (w_start) r_ts_lat <= r_ts;
    end
  end
`endif

  always_comb begin
    w_tdata = '0;
    case (r_state)
      ST_HDR:  w_tdata = make_hdr(r_seq, r_n);
`ifdef TRADE_PACKER_TIMESTAMP_EN
      ST_TS:   w_tdata = r_ts_lat;
`endif
      ST_PAY:  w_tdata = w_fifo_dout;
      default: w_tdata = '0;
    endcase
  end

  assign o_m_tdata        = w_tdata;
  assign o_m_tvalid       = (r_state != ST_IDLE);
  assign o_m_tlast        = (r_state == ST_PAY) && w_last;
  assign o_fifo_level     = w_level;
  assign o_overflow_count = r_ovf;
  assign o_busy           = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule
